gerenciador_de_ataque_n: RTL

GERENCIADOR_DE_ATAQUE_N -- requirements
Module: gerenciador_de_ataque_n

---
 rtl/gerenciador_de_ataque_n.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gerenciador_de_ataque_n.sv
// gerenciador_de_ataque_n
// Shot manager for a battleship-style board. Each rising edge of the fire
// button, taken while a game is in progress, is classified as out of range,
// repeat, hit or miss. The hit/fired maps, the LED that reports the result
// and the remaining lives update on the clock edge that samples the shot.
// The following edge decides between win, loss or continuing to play.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   enable       game active; low clears the game back to IDLE
//   confirmar    fire button (level); a shot is taken on its rising edge
//   coordColuna  target column
//   coordLinha   target row
//   mapa         ship map, bit index = coluna*ROWS + linha
//   matriz       cells that were hit (same indexing)
//   tiros        cells already fired on (same indexing)
//   LED_R        last shot missed
//   LED_G        last shot hit
//   LED_B        last shot repeated or out of range
//   vida         remaining lives
//   vitoria      all ship cells hit
//   derrota      lives exhausted
//
// state   | meaning
// IDLE    | game cleared, waiting for enable
// JOGANDO | waiting for a shot
// CHECA   | shot just applied, deciding win / loss / continue
// VITORIA | won, held until enable drops or reset
// DERROTA | lost, held until enable drops or reset

module gerenciador_de_ataque_n #(
   parameter int COLS  = 5,
   parameter int ROWS  = 7,
   parameter int VIDAS = 3,
   localparam int VW   = $clog2(VIDAS + 1),
   localparam int N    = COLS * ROWS
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic          confirmar,
   input  logic [2:0]    coordColuna,
   input  logic [2:0]    coordLinha,
   input  logic [N-1:0]  mapa,
   output logic [N-1:0]  matriz,
   output logic [N-1:0]  tiros,
   output logic          LED_R,
   output logic          LED_G,
   output logic          LED_B,
   output logic [VW-1:0] vida,
   output logic          vitoria,
   output logic          derrota
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      JOGANDO = 3'd1,
      CHECA   = 3'd2,
      VITORIA = 3'd3,
      DERROTA = 3'd4
   } estado_t;

   estado_t       r_estado;
   logic          r_conf_q;
   logic [N-1:0]  r_matriz;
   logic [N-1:0]  r_tiros;
   logic          r_led_r;
   logic          r_led_g;
   logic          r_led_b;
   logic [VW-1:0] r_vida;
   logic          r_vitoria;
   logic          r_derrota;

   logic          w_evento;
   logic          w_in_range;
   logic [31:0]   w_idx;
   logic [N-1:0]  w_sel;
   logic          w_repetido;
   logic          w_acerto;
   logic          w_ganhou;

   assign w_evento   = confirmar & ~r_conf_q;
   assign w_in_range = ({29'd0, coordColuna} < 32'(COLS)) &&
                       ({29'd0, coordLinha}  < 32'(ROWS));
   assign w_idx      = {29'd0, coordColuna} * 32'(ROWS) + {29'd0, coordLinha};
   // One-hot cell select; only meaningful when w_in_range is set.
   assign w_sel      = N'(1) << w_idx;
   assign w_repetido = |(r_tiros & w_sel);
   assign w_acerto   = |(mapa & w_sel);
   // An empty map can never be won.
   assign w_ganhou   = ((r_matriz & mapa) == mapa) && (mapa != '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado  <= IDLE;
         r_conf_q  <= 1'b0;
         r_matriz  <= '0;
         r_tiros   <= '0;
         r_led_r   <= 1'b0;
         r_led_g   <= 1'b0;
         r_led_b   <= 1'b0;
         r_vida    <= VW'(VIDAS);
         r_vitoria <= 1'b0;
         r_derrota <= 1'b0;
      end else begin
         r_conf_q <= confirmar;
         if (!enable) begin
            r_estado  <= IDLE;
            r_matriz  <= '0;
            r_tiros   <= '0;
            r_led_r   <= 1'b0;
            r_led_g   <= 1'b0;
            r_led_b   <= 1'b0;
            r_vida    <= VW'(VIDAS);
            r_vitoria <= 1'b0;
            r_derrota <= 1'b0;
         end else begin
            case (r_estado)
               IDLE: r_estado <= JOGANDO;
               JOGANDO: begin
                  if (w_evento) begin
                     r_estado <= CHECA;
                     if (!w_in_range || w_repetido) begin
                        r_led_r <= 1'b0;
                        r_led_g <= 1'b0;
                        r_led_b <= 1'b1;
                     end else if (w_acerto) begin
                        r_tiros  <= r_tiros | w_sel;
                        r_matriz <= r_matriz | w_sel;
                        r_led_r  <= 1'b0;
                        r_led_g  <= 1'b1;
                        r_led_b  <= 1'b0;
                     end else begin
                        r_tiros <= r_tiros | w_sel;
                        r_led_r <= 1'b1;
                        r_led_g <= 1'b0;
                        r_led_b <= 1'b0;
                        if (r_vida != '0)
                           r_vida <= r_vida - VW'(1);
                     end
                  end
               end
               CHECA: begin
                  if (w_ganhou) begin
                     r_estado  <= VITORIA;
                     r_vitoria <= 1'b1;
                  end else if (r_vida == '0) begin
                     r_estado  <= DERROTA;
                     r_derrota <= 1'b1;
                  end else begin
                     r_estado <= JOGANDO;
                  end
               end
               VITORIA: r_estado <= VITORIA;
               DERROTA: r_estado <= DERROTA;
               default: r_estado <= IDLE;
            endcase
         end
      end
   end

   assign matriz  = r_matriz;
   assign tiros   = r_tiros;
   assign LED_R   = r_led_r;
   assign LED_G   = r_led_g;
   assign LED_B   = r_led_b;
   assign vida    = r_vida;
   assign vitoria = r_vitoria;
   assign derrota = r_derrota;

endmodule
